// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: RISC-V width codes, FSM states and
// the access-size helper used by the optional bounds check.
package lsu_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    STORE  = 3'd3,
    RESP   = 3'd4
  } state_t;

  // Bytes touched by an access; invalid codes report a word so they never
  // look smaller than a real access.
  function automatic logic [2:0] access_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: access_size = 3'd1;
      F3_H, F3_HU: access_size = 3'd2;
      default:     access_size = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// CPU-side request/response and RAM data-port signals of the load/store unit.
interface load_store_unit_if;
  // Handshake: a request transfers on a rising edge where req && ready; the
  // requester holds req/we/funct3/addr/wdata stable until then. The response
  // is the single-cycle done pulse, with err and rdata valid alongside it.
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic [31:0] mem_rdata;

  modport master (
    output req, we, funct3, addr, wdata, mem_rdata,
    input  ready, done, err, rdata, mem_addr, mem_wdata, mem_wr
  );

  modport slave (
    input  req, we, funct3, addr, wdata, mem_rdata,
    output ready, done, err, rdata, mem_addr, mem_wdata, mem_wr
  );
endinterface

// File: rtl/lsu_align.sv
// Lane extraction for loads and lane merge for sub-word stores; purely
// combinational so LOAD and RMW_RD share one instance.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] load_val,
  output logic [31:0] store_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rd_word[8*offset +: 8];
    half_lane = rd_word[16*offset[1] +: 16];

    case (funct3)
      F3_B:    load_val = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    load_val = {{16{half_lane[15]}}, half_lane};
      F3_BU:   load_val = {24'h0, byte_lane};
      F3_HU:   load_val = {16'h0, half_lane};
      default: load_val = rd_word;
    endcase

    // Only the addressed lane changes; the rest of the old word is kept.
    store_word = rd_word;
    case (funct3)
      F3_B:    store_word[8*offset +: 8]       = wdata[7:0];
      F3_H:    store_word[16*offset[1] +: 16]  = wdata[15:0];
      default: store_word                      = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: word-aligned RAM accesses, sub-word stores by read-modify-write.
// Optional macro LSU_BOUNDS_CHECK_EN rejects accesses that run past MEM_BYTES.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  load_store_unit_if.slave   bus,
  output state_t             dbg_state
);

  state_t      state;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic        ready_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic        mem_wr_q;
  logic        req_err;
  logic [31:0] load_val;
  logic [31:0] store_word;

  if (MEM_BYTES < 4) begin : g_mem_bytes_small
  end

  always_comb begin
    req_err = 1'b0;
    case (bus.funct3)
      F3_B:    req_err = 1'b0;
      F3_BU:   req_err = bus.we;
      F3_H:    req_err = bus.addr[0];
      F3_HU:   req_err = bus.we | bus.addr[0];
      F3_W:    req_err = (bus.addr[1:0] != 2'b00);
      default: req_err = 1'b1;
    endcase
`ifdef LSU_BOUNDS_CHECK_EN
    // 33-bit sum so an address near 2^32 cannot wrap back into range.
    if (({1'b0, bus.addr} + 33'(access_size(bus.funct3))) > 33'(MEM_BYTES))
      req_err = 1'b1;
`endif
  end

  lsu_align u_align (
    .rd_word    (bus.mem_rdata),
    .wdata      (wdata_q),
    .offset     (off_q),
    .funct3     (f3_q),
    .load_val   (load_val),
    .store_word (store_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      wdata_q     <= 32'h0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_wr_q    <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      mem_wr_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            ready_q <= 1'b0;
            f3_q    <= bus.funct3;
            off_q   <= bus.addr[1:0];
            wdata_q <= bus.wdata;
            if (req_err) begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
              state  <= RESP;
            end else begin
              err_q      <= 1'b0;
              mem_addr_q <= {bus.addr[31:2], 2'b00};
              if (!bus.we) begin
                state <= LOAD;
              end else if (bus.funct3 == F3_W) begin
                mem_wdata_q <= bus.wdata;
                mem_wr_q    <= 1'b1;
                state       <= STORE;
              end else begin
                state <= RMW_RD;
              end
            end
          end
        end
        LOAD: begin
          rdata_q <= load_val;
          done_q  <= 1'b1;
          state   <= RESP;
        end
        RMW_RD: begin
          mem_wdata_q <= store_word;
          mem_wr_q    <= 1'b1;
          state       <= STORE;
        end
        STORE: begin
          done_q <= 1'b1;
          state  <= RESP;
        end
        RESP: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wr    = mem_wr_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a small RAM model, a driver that pushes
// expected responses and writes into queues, and a monitor that pops them.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int EW = 66;  // {err, check_rdata, rdata[31:0], cycle[31:0]}
  localparam int WW = 96;  // {mem_addr, mem_wdata, cycle}

  logic   clk;
  logic   rst_n;
  state_t dbg_state;
  int     cyc;
  int     errors;
  int     checks;
  logic [31:0] model_rd;
  logic [31:0] ram [0:1023];
  logic [EW-1:0] exp_q[$];
  logic [WW-1:0] wr_q[$];

  load_store_unit_if bus ();

  load_store_unit #(.MEM_BYTES(4096)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / RAM model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_wr) ram[bus.mem_addr[11:2]] <= bus.mem_wdata;
  end

  assign bus.mem_rdata = ram[bus.mem_addr[11:2]];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  // ---------------- scoreboard helpers ----------------
  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [WW-1:0] w;
    if (rst_n) begin
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: actual=done required=idle at cycle %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", 32'(cyc), e[31:0]);
          check("err", {31'h0, bus.err}, {31'h0, e[65]});
          if (e[64]) check("rdata", bus.rdata, e[63:32]);
        end
      end
      if (bus.mem_wr) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_wr_unexpected: actual=write 0x%08h required=no write at cycle %0d",
                   bus.mem_addr, cyc);
        end else begin
          w = wr_q.pop_front();
          check("mem_addr", bus.mem_addr, w[95:64]);
          check("mem_wdata", bus.mem_wdata, w[63:32]);
          check("mem_wr_cycle", 32'(cyc), w[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd,
                       input int e_lat, input logic e_wr, input logic [31:0] e_wdata,
                       input int e_wlat);
    int  acc;
    bit  got;
    got = 1'b0;
    @(negedge clk);
    bus.req    = 1'b1;
    bus.we     = w;
    bus.funct3 = f3;
    bus.addr   = a;
    bus.wdata  = wd;
    for (int i = 0; i < 20; i++) begin
      if (bus.ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept: actual=ready low for 20 cycles required=ready");
      bus.req = 1'b0;
      return;
    end
    acc = cyc;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    exp_q.push_back({e_err, 1'b1, e_rd, 32'(acc + e_lat)});
    if (e_wr) wr_q.push_back({a[31:2], 2'b00, e_wdata, 32'(acc + e_wlat)});
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp_rd);
    model_rd = exp_rd;
    issue(1'b0, f3, a, 32'h0, 1'b0, exp_rd, 2, 1'b0, 32'h0, 0);
  endtask

  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_word);
    if (f3 == F3_W) issue(1'b1, f3, a, wd, 1'b0, model_rd, 2, 1'b1, exp_word, 1);
    else            issue(1'b1, f3, a, wd, 1'b0, model_rd, 3, 1'b1, exp_word, 2);
  endtask

  task automatic do_err(input logic w, input logic [2:0] f3, input logic [31:0] a);
    issue(w, f3, a, 32'hFFFF_FFFF, 1'b1, model_rd, 1, 1'b0, 32'h0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    errors     = 0;
    checks     = 0;
    cyc        = 0;
    model_rd   = 32'h0;
    rst_n      = 1'b0;
    bus.req    = 1'b0;
    bus.we     = 1'b0;
    bus.funct3 = 3'b000;
    bus.addr   = 32'h0;
    bus.wdata  = 32'h0;
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    ram[32'h100 >> 2] = 32'h8899_AABB;
    ram[32'hFFC >> 2] = 32'h0BAD_F00D;

    repeat (3) @(negedge clk);
    check("rst_ready", {31'h0, bus.ready}, 32'h1);
    check("rst_done", {31'h0, bus.done}, 32'h0);
    check("rst_err", {31'h0, bus.err}, 32'h0);
    check("rst_mem_wr", {31'h0, bus.mem_wr}, 32'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_state", {29'h0, dbg_state}, {29'h0, IDLE});
    rst_n = 1'b1;

    do_load(F3_B,  32'h102, 32'hFFFF_FF99);
    do_load(F3_HU, 32'h102, 32'h0000_8899);
    do_load(F3_H,  32'h100, 32'hFFFF_AABB);
    do_load(F3_BU, 32'h100, 32'h0000_00BB);
    do_store(F3_B, 32'h101, 32'h1234_5677, 32'h8899_77BB);
    do_load(F3_W,  32'h100, 32'h8899_77BB);
    do_store(F3_W, 32'h200, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_load(F3_W,  32'h200, 32'hDEAD_BEEF);
    do_store(F3_H, 32'h202, 32'h0000_CAFE, 32'hCAFE_BEEF);
    do_load(F3_H,  32'h202, 32'hFFFF_CAFE);

    // Requests raised while busy must be dropped, not queued.
    do_load(F3_B,  32'h203, 32'hFFFF_FFCA);
    @(negedge clk);
    check("busy_ready_load", {31'h0, bus.ready}, 32'h0);
    bus.req    = 1'b1;
    bus.we     = 1'b0;
    bus.funct3 = 3'b010;
    bus.addr   = 32'h100;
    @(negedge clk);
    check("busy_ready_resp", {31'h0, bus.ready}, 32'h0);
    @(negedge clk);
    bus.req = 1'b0;

    do_err(1'b0, 3'b010, 32'h102);
    do_err(1'b0, 3'b011, 32'h100);
    do_err(1'b1, 3'b100, 32'h100);
    do_err(1'b1, 3'b101, 32'h100);
    do_err(1'b1, 3'b001, 32'h101);
    do_err(1'b0, 3'b101, 32'h103);
    do_err(1'b0, 3'b110, 32'h100);
    do_err(1'b1, 3'b111, 32'h100);
    do_err(1'b1, 3'b010, 32'h202);
    do_load(F3_BU, 32'h201, 32'h0000_00BE);

    do_load(F3_W,  32'hFFC, 32'h0BAD_F00D);
    do_store(F3_H, 32'hFFE, 32'h1111_2222, 32'h2222_F00D);
    do_load(F3_HU, 32'hFFE, 32'h0000_2222);
`ifdef LSU_BOUNDS_CHECK_EN
    do_err(1'b1, 3'b001, 32'hFFF);
    do_err(1'b0, 3'b010, 32'h1000);
    do_err(1'b0, 3'b000, 32'h1000);
`endif

    // Reset during the read half of a byte store abandons it.
    do_store(F3_B, 32'h100, 32'h0000_0055, 32'h8899_7755);
    check("rmw_state", {29'h0, dbg_state}, {29'h0, RMW_RD});
    rst_n = 1'b0;
    exp_q.delete();
    wr_q.delete();
    model_rd = 32'h0;
    repeat (2) @(negedge clk);
    check("midrst_ready", {31'h0, bus.ready}, 32'h1);
    check("midrst_mem_wr", {31'h0, bus.mem_wr}, 32'h0);
    check("midrst_rdata", bus.rdata, 32'h0);
    check("midrst_state", {29'h0, dbg_state}, {29'h0, IDLE});
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_ready", {31'h0, bus.ready}, 32'h1);
    do_load(F3_W, 32'h100, 32'h8899_77BB);

    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && wr_q.size() == 0) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("pending_done", 32'(exp_q.size()), 32'h0);
    check("pending_writes", 32'(wr_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the CPU execute stage and the data port of the dual-port RAM.
- Turns RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into word-aligned RAM accesses.
- Loads: extracts the byte or halfword lane from the read word and sign- or zero-extends it.
- Stores: the RAM only accepts full-word writes, so SB/SH use read-modify-write.
- Misaligned and invalid requests complete with an error and never touch memory.

Parameters:
- MEM_BYTES, 4096, size of the data address space in bytes; used only by the optional bounds check.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  1  request valid; accepted when req && ready
- we  input  1  1 = store, 0 = load
- funct3  input  3  RISC-V width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  input  32  byte address
- wdata  input  32  store data; low bits used for B/H
- ready  output  1  high only in IDLE
- done  output  1  one-cycle completion pulse
- err  output  1  valid with done; request was misaligned, invalid or out of bounds
- rdata  output  32  load result; held until the next completed load
- mem_addr  output  32  RAM address, always {addr[31:2],2'b00}
- mem_wdata  output  32  RAM write data
- mem_wr  output  1  RAM write strobe, single cycle
- mem_rdata  input  32  RAM combinational read data at mem_addr

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - ready=1; done, err, mem_wr = 0.
  - rdata, mem_addr, mem_wdata and all captured registers = 0.
  - Reset mid-operation abandons the access; no mem_wr is issued after reset deasserts.
- States: IDLE, LOAD, RMW_RD, STORE, RESP.
- IDLE, on accept: capture we, funct3, addr, wdata.
  - err condition, any of:
    - funct3 in {011,110,111}
    - H/HU/SH with addr[0]=1
    - W/SW with addr[1:0]!=0
    - store with funct3 BU/HU
  - err condition -> RESP with err=1; no RAM access.
  - Load -> LOAD.
  - SW -> STORE.
  - SB/SH -> RMW_RD.
- LOAD:
  - mem_addr = aligned address.
  - rdata <= extract(mem_rdata, addr[1:0], funct3).
  - Lane selection: byte = mem_rdata[8*addr[1:0] +: 8]; half = mem_rdata[16*addr[1] +: 16].
  - Extension: B/H sign-extend; BU/HU zero-extend.
  - Next state: RESP.
- RMW_RD:
  - mem_addr = aligned address.
  - Capture merge(mem_rdata, wdata, addr[1:0], funct3) into mem_wdata: only the target lane is replaced.
  - Next state: STORE.
- STORE:
  - mem_wr=1 for exactly this cycle.
  - mem_wdata = merged word, or wdata for SW.
  - Next state: RESP.
- RESP: done=1 and err as determined, then IDLE.
- Latency from accept to done:
  - error: 1 cycle
  - load: 2 cycles
  - SW: 2 cycles
  - SB/SH: 3 cycles
- ready=0 outside IDLE; req is ignored there and not queued. The requester must hold req until it sees ready.
- rdata updates only on a successful load; stores and errors leave it unchanged.
- mem_addr holds its last value in IDLE and RESP; mem_wr=0 in every state except STORE.
- mem_rdata is sampled in the same cycle mem_addr is driven; the RAM read is combinational.

Optional Feature:
- Macro: LSU_BOUNDS_CHECK_EN.
- Defined: any access with addr + access_size > MEM_BYTES completes through RESP with err=1 and no RAM access. Example: LW at 0xFFC is legal, LW at 0x1000 errors.
- Undefined: no bounds check; addresses pass through unchanged and MEM_BYTES is unused.

Decomposition:
- Package lsu_pkg:
  - funct3 enum: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - state enum: IDLE, LOAD, RMW_RD, STORE, RESP.
  - Function access_size(funct3).
- Sub-module lsu_align: purely combinational.
  - extract path: mem_rdata, offset, funct3 -> extended load value.
  - merge path: old word, wdata, offset, funct3 -> store word.
  - Instantiated once, shared by LOAD and RMW_RD.

Test Plan:
- RAM word 0x0000_0100 = 0x8899_AABB; LB addr 0x102 -> done at accept+2, rdata=0xFFFF_FF99, err=0, mem_wr never asserted.
- Same word; LHU 0x102 -> rdata=0x0000_8899; LH 0x100 -> rdata=0xFFFF_AABB.
- Same word; SB 0x101 with wdata=0x1234_5677 -> one mem_wr at accept+2 with mem_wdata=0x8899_77BB; a following LW 0x100 returns 0x8899_77BB.
- SW 0x200 with wdata=0xDEAD_BEEF -> mem_wr at accept+1 with mem_addr=0x200; then LW 0x200 -> rdata=0xDEAD_BEEF.
- LW 0x102 and funct3=011 -> done with err=1 at accept+1, no mem_wr, rdata unchanged; req pulses while busy produce no extra done.
- Assert rst_n=0 during RMW_RD of an SB -> mem_wr never rises, ready=1 after reset; with LSU_BOUNDS_CHECK_EN, SH 0xFFF -> err=1 (misaligned) and LW 0x1000 -> err=1.
